// File: rtl/transformer_pkg.sv
// Shared types and helpers for the transformer layer sequencer.
package transformer_pkg;

   // Widest element the saturating helper supports.
   localparam int MAX_DW = 16;

   typedef enum logic [1:0] {
      OP_LN1 = 2'd0,
      OP_ATT = 2'd1,
      OP_LN2 = 2'd2,
      OP_FFN = 2'd3
   } stage_op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LN1,
      S_ATT,
      S_LN2,
      S_FFN,
      S_OUT
   } state_t;

   // Adds two sign-extended dw-bit values with one guard bit and clamps the
   // result to the signed dw-bit range.
   function automatic logic signed [MAX_DW-1:0] sat_add(
      input logic signed [MAX_DW-1:0] a,
      input logic signed [MAX_DW-1:0] b,
      input int                       dw
   );
      logic signed [MAX_DW:0] sum;
      logic signed [MAX_DW:0] hi;
      logic signed [MAX_DW:0] lo;
      sum = {a[MAX_DW-1], a} + {b[MAX_DW-1], b};
      hi  = (MAX_DW+1)'((1 << (dw - 1)) - 1);
      lo  = ~hi;
      if (sum > hi)
         return MAX_DW'(hi);
      else if (sum < lo)
         return MAX_DW'(lo);
      return MAX_DW'(sum);
   endfunction

endpackage

// File: rtl/residual_sat_add.sv
// Element-wise saturating vector adder used for both residual updates.
module residual_sat_add
   import transformer_pkg::*;
#(
   parameter int D  = 4,
   parameter int DW = 8
) (
   input  logic [D-1:0][DW-1:0] a,
   input  logic [D-1:0][DW-1:0] b,
   output logic [D-1:0][DW-1:0] y
);

   for (genvar i = 0; i < D; i++) begin : g_el
      logic signed [MAX_DW-1:0] ax;
      logic signed [MAX_DW-1:0] bx;
      logic signed [MAX_DW-1:0] sx;
      // Sign-extend each lane into the helper's width, clamp, then narrow back.
      assign ax   = MAX_DW'($signed(a[i]));
      assign bx   = MAX_DW'($signed(b[i]));
      assign sx   = sat_add(ax, bx, DW);
      assign y[i] = DW'(sx);
   end

endmodule

// File: rtl/transformer_layer_seq.sv
// Multi-layer pre-LN transformer sequencer: walks each token through
// LN1 -> ATT -> LN2 -> FFN per layer on a shared stage engine, keeping the
// residual stream locally and returning the result over valid/ready.
module transformer_layer_seq
   import transformer_pkg::*;
#(
   parameter int D        = 4,
   parameter int DW       = 8,
   parameter int N_LAYERS = 2,
   parameter int SEQ_LEN  = 4,
   parameter int TMO_W    = 16,
   localparam int LW      = $clog2(N_LAYERS) + 1,
   localparam int TOKW    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 abort,
   input  logic [TMO_W-1:0]     timeout_limit,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [D-1:0][DW-1:0] in_vec,
   output logic                 stage_start,
   output logic [1:0]           stage_op,
   output logic [LW-1:0]        layer_idx,
   output logic [D-1:0][DW-1:0] stage_in,
   input  logic                 stage_done,
   input  logic [D-1:0][DW-1:0] stage_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [D-1:0][DW-1:0] out_vec,
   output logic                 out_last,
   output logic                 busy,
   output logic                 timeout_err
);

   state_t                state;
   stage_op_t             op;
   logic [D-1:0][DW-1:0]  res;
   logic [D-1:0][DW-1:0]  tmp;
   logic [D-1:0][DW-1:0]  sum;
   logic [LW-1:0]         layer;
   logic [TMO_W-1:0]      wait_cnt;
   logic [TOKW-1:0]       tok_idx;
   logic                  in_stage;
   logic                  done_ok;
   logic                  tmo_hit;
   logic                  last_tok;

   residual_sat_add #(.D(D), .DW(DW)) u_add (
      .a (res),
      .b (stage_out),
      .y (sum)
   );

   assign in_stage = (state inside {S_LN1, S_ATT, S_LN2, S_FFN});
   // The entry cycle's done is ignored so a stale pulse cannot close a new stage.
   assign done_ok  = in_stage && stage_done && !stage_start;
   assign tmo_hit  = in_stage && (timeout_limit != '0) && (wait_cnt == timeout_limit);
   assign last_tok = (tok_idx == TOKW'(SEQ_LEN - 1));

   // Map the sequencer state onto the engine opcode.
   always_comb begin
      op = OP_LN1;
      case (state)
         S_ATT:   op = OP_ATT;
         S_LN2:   op = OP_LN2;
         S_FFN:   op = OP_FFN;
         default: op = OP_LN1;
      endcase
   end

   assign stage_op    = op;
   assign layer_idx   = in_stage ? layer : '0;
   assign stage_in    = (state == S_ATT || state == S_FFN) ? tmp : res;
   assign in_ready    = (state == S_IDLE) && !abort;
   assign busy        = (state != S_IDLE);
   assign out_valid   = (state == S_OUT);
   assign out_vec     = out_valid ? res : '0;
   assign out_last    = out_valid && last_tok;

   // Sequencer: token accept, stage walk, residual updates, timeout and output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         stage_start <= 1'b0;
         res         <= '0;
         tmp         <= '0;
         layer       <= '0;
         wait_cnt    <= '0;
         tok_idx     <= '0;
         timeout_err <= 1'b0;
      end else if (abort) begin
         state       <= S_IDLE;
         stage_start <= 1'b0;
         tok_idx     <= '0;
         timeout_err <= 1'b0;
      end else begin
         stage_start <= 1'b0;
         wait_cnt    <= wait_cnt + TMO_W'(1);
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  res         <= in_vec;
                  layer       <= '0;
                  state       <= S_LN1;
                  stage_start <= 1'b1;
                  wait_cnt    <= '0;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  tok_idx <= last_tok ? '0 : tok_idx + TOKW'(1);
                  state   <= S_IDLE;
               end
            end
            default: begin
               if (done_ok) begin
                  wait_cnt    <= '0;
                  stage_start <= 1'b1;
                  case (state)
                     S_LN1: begin
                        tmp   <= stage_out;
                        state <= S_ATT;
                     end
                     S_ATT: begin
                        res   <= sum;
                        state <= S_LN2;
                     end
                     S_LN2: begin
                        tmp   <= stage_out;
                        state <= S_FFN;
                     end
                     default: begin
                        res <= sum;
                        if (layer == LW'(N_LAYERS - 1)) begin
                           state       <= S_OUT;
                           stage_start <= 1'b0;
                        end else begin
                           layer <= layer + LW'(1);
                           state <= S_LN1;
                        end
                     end
                  endcase
               end else if (tmo_hit) begin
                  // Engine never answered: drop the token, keep tok_idx.
                  timeout_err <= 1'b1;
                  state       <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_transformer_layer_seq.sv
// Self-checking bench for transformer_layer_seq with a behavioural engine
// and a vector-level reference model of the layer stack.
module tb_transformer_layer_seq;

   localparam int D   = 4;
   localparam int DW  = 8;
   localparam int NL  = 2;
   localparam int SL  = 4;
   localparam int TMW = 16;
   localparam int LW  = $clog2(NL) + 1;
   localparam int NS  = 4 * NL;

   typedef logic [D-1:0][DW-1:0] vec_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           abort = 1'b0;
   logic [TMW-1:0] timeout_limit = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   vec_t           in_vec = '0;
   logic           stage_start;
   logic [1:0]     stage_op;
   logic [LW-1:0]  layer_idx;
   vec_t           stage_in;
   logic           stage_done = 1'b0;
   vec_t           stage_out = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   vec_t           out_vec;
   logic           out_last;
   logic           busy;
   logic           timeout_err;

   transformer_layer_seq #(.D(D), .DW(DW), .N_LAYERS(NL), .SEQ_LEN(SL), .TMO_W(TMW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .abort         (abort),
      .timeout_limit (timeout_limit),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_vec        (in_vec),
      .stage_start   (stage_start),
      .stage_op      (stage_op),
      .layer_idx     (layer_idx),
      .stage_in      (stage_in),
      .stage_done    (stage_done),
      .stage_out     (stage_out),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_vec       (out_vec),
      .out_last      (out_last),
      .busy          (busy),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_pass = 0;
   int   lat = 1;
   bit   silent_att = 1'b0;
   int   c[4];
   int   b[4];
   int   lb[4];
   int   tok = 0;
   vec_t exp_in[NS];
   vec_t exp_out;
   vec_t last_out;
   int   log_op[$];
   int   log_ly[$];
   vec_t log_in[$];
   bit   in_moved = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Engine transfer function: y = x*c[op] + b[op] + layer*lb[op], wrapped to DW bits.
   function automatic vec_t eng(input int op, input int ly, input vec_t x);
      vec_t r;
      for (int i = 0; i < D; i++)
         r[i] = DW'(int'($signed(x[i])) * c[op] + b[op] + ly * lb[op]);
      return r;
   endfunction

   function automatic vec_t sat(input vec_t a, input vec_t e);
      vec_t r;
      int   s;
      for (int i = 0; i < D; i++) begin
         s = int'($signed(a[i])) + int'($signed(e[i]));
         if (s > (1 << (DW - 1)) - 1) s = (1 << (DW - 1)) - 1;
         else if (s < -(1 << (DW - 1))) s = -(1 << (DW - 1));
         r[i] = DW'(s);
      end
      return r;
   endfunction

   // Reference: expected engine operand per stage and final residual.
   task automatic model(input vec_t v);
      vec_t r;
      vec_t t;
      r = v;
      for (int l = 0; l < NL; l++) begin
         exp_in[4*l]   = r;
         t = eng(0, l, r);
         exp_in[4*l+1] = t;
         r = sat(r, eng(1, l, t));
         exp_in[4*l+2] = r;
         t = eng(2, l, r);
         exp_in[4*l+3] = t;
         r = sat(r, eng(3, l, t));
      end
      exp_out = r;
   endtask

   // Behavioural stage engine with latency lat; logs every start it sees.
   initial begin : engine
      bit   pend;
      int   cnt;
      int   op;
      int   ly;
      vec_t x;
      pend = 1'b0; cnt = 0; op = 0; ly = 0; x = '0;
      forever begin
         @(negedge clk);
         stage_done = 1'b0;
         if (pend) begin
            if (stage_in !== x) in_moved = 1'b1;
            cnt--;
            if (cnt == 0) begin
               pend = 1'b0;
               if (!(silent_att && op == 1)) begin
                  stage_done = 1'b1;
                  stage_out  = eng(op, ly, x);
               end
            end
         end
         if (stage_start) begin
            pend = 1'b1;
            cnt  = lat;
            op   = int'(stage_op);
            ly   = int'(layer_idx);
            x    = stage_in;
            log_op.push_back(op);
            log_ly.push_back(ly);
            log_in.push_back(x);
         end
      end
   end

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < D; i++) v[i] = DW'($urandom);
      return v;
   endfunction

   task automatic rand_engine();
      for (int k = 0; k < 4; k++) begin
         c[k]  = int'($urandom_range(0, 4)) - 2;
         b[k]  = int'($urandom_range(0, 100)) - 50;
         lb[k] = int'($urandom_range(0, 20)) - 10;
      end
   endtask

   task automatic accept(input vec_t v);
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      log_op.delete(); log_ly.delete(); log_in.delete();
      in_moved = 1'b0;
      in_vec   = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_stage(input int op, input int ly);
      int k;
      bit found;
      k = 0;
      found = 1'b0;
      do begin
         @(negedge clk);
         k++;
         found = stage_start && (int'(stage_op) == op) && (int'(layer_idx) == ly);
      end while (!found && k < 100);
      chk($sformatf("reach_op%0d_l%0d", op, ly), found, 1);
   endtask

   task automatic run_token(input vec_t v, input int bp);
      int   k;
      bit   ir_bad;
      vec_t held;
      model(v);
      out_ready = (bp == 0);
      accept(v);
      k = 0;
      ir_bad = 1'b0;
      do begin
         @(negedge clk);
         k++;
         if (in_ready) ir_bad = 1'b1;
      end while (!out_valid && k < 200);
      chk("latency", k, 1 + NS * (lat + 1));
      chk("in_ready_busy", ir_bad, 0);
      if (!out_valid) begin
         out_ready = 1'b1;
         return;
      end
      held = out_vec;
      for (int i = 0; i < bp; i++) begin
         chk("bp_hold", {out_valid, in_ready, out_last, out_vec}, {1'b1, 1'b0, tok == SL - 1, held});
         @(negedge clk);
      end
      out_ready = 1'b1;
      last_out  = out_vec;
      chk("out_vec", out_vec, exp_out);
      chk("out_last", out_last, tok == SL - 1);
      @(posedge clk);
      tok = (tok + 1) % SL;
      @(negedge clk);
      chk("after_hs", {out_valid, in_ready}, 2'b01);
      chk("n_starts", log_op.size(), NS);
      for (int i = 0; i < NS && i < log_op.size(); i++)
         chk($sformatf("stage%0d", i), {2'(log_op[i]), 6'(log_ly[i]), log_in[i]},
             {2'(i % 4), 6'(i / 4), exp_in[i]});
      chk("stage_in_stable", in_moved, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      vec_t v;
      vec_t k_sat;
      // Reset state
      #2;
      chk("rst_ctl", {stage_start, stage_op, layer_idx, out_valid, out_last, busy, timeout_err}, 0);
      chk("rst_data", {stage_in, out_vec}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);

      // Pass-through engine
      c = '{1, 0, 1, 0}; b = '{0, 0, 0, 0}; lb = '{0, 0, 0, 0}; lat = 1;
      for (int i = 0; i < D; i++) v[i] = DW'(i + 1);
      run_token(v, 0);
      chk("pass_out", last_out, v);

      // Saturation: ATT returns 100 per element
      b = '{0, 100, 0, 0};
      v[0] = 8'sd100; v[1] = -8'sd128; v[2] = 8'sd0; v[3] = 8'sd27;
      run_token(v, 0);
      k_sat[0] = 8'sd127; k_sat[1] = -8'sd28; k_sat[2] = 8'sd100; k_sat[3] = 8'sd127;
      chk("sat_layer0", log_in.size() > 4 ? log_in[4] : '0, k_sat);
      k_sat[1] = 8'sd72; k_sat[2] = 8'sd127;
      chk("sat_out", last_out, k_sat);

      // abort with in_valid in IDLE: no accept, tok_idx cleared
      @(negedge clk);
      in_vec = rand_vec(); in_valid = 1'b1; abort = 1'b1;
      #1 chk("abort_blocks_ready", in_ready, 0);
      @(posedge clk);
      #1 in_valid = 1'b0; abort = 1'b0;
      tok = 0;
      @(negedge clk);
      chk("abort_no_accept", busy, 0);

      // Random tokens, backpressure on the second, last flag on the fourth
      rand_engine();
      lat = int'($urandom_range(1, 3));
      for (int t = 0; t < 5; t++) run_token(rand_vec(), (t == 1) ? 5 : 0);

      // Timeout: silent ATT engine
      timeout_limit = 3; lat = 1; silent_att = 1'b1;
      accept(rand_vec());
      wait_stage(1, 0);
      repeat (3) @(negedge clk);
      chk("tmo_pending", {busy, timeout_err}, 2'b10);
      @(negedge clk);
      chk("tmo_fire", {timeout_err, in_ready, busy, out_valid}, 4'b1100);
      silent_att = 1'b0;

      // Abort during LN2 clears the sticky error
      timeout_limit = 0;
      accept(rand_vec());
      wait_stage(2, 0);
      chk("err_sticky", timeout_err, 1);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      tok = 0;
      @(negedge clk);
      chk("abort_ln2", {busy, timeout_err, stage_start, out_valid}, 0);
      repeat (2) @(negedge clk);

      // done arriving exactly in the limit cycle wins over the timeout
      timeout_limit = 3; lat = 3;
      rand_engine();
      run_token(rand_vec(), 0);
      chk("no_tmo_err", timeout_err, 0);

      // Asynchronous reset during FFN of layer 1
      timeout_limit = 0; lat = 1;
      accept(rand_vec());
      wait_stage(3, 1);
      #1 rst_n = 1'b0;
      #1 chk("rst_mid", {out_valid, busy, stage_start, timeout_err, stage_op, layer_idx}, 0);
      tok = 0;
      @(negedge clk) rst_n = 1'b1;
      #1 chk("rst_mid_ready", in_ready, 1);
      repeat (3) @(negedge clk);

      // Normal operation after reset
      rand_engine();
      run_token(rand_vec(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/transformer_layer_seq.md
# transformer_layer_seq

Parametrised multi-layer sequencer for the pre-LN transformer datapath. It accepts one token vector at a time and holds the true residual stream in an internal register. For each of N_LAYERS layers it drives a shared stage-engine port through LN1 → ATT → LN2 → FFN, with saturating residual adds after ATT and FFN. It returns the final vector over a valid/ready output. It replaces the single-layer, fire-and-forget block controller and adds per-stage timeout, abort and output backpressure.

## Interface
- D, 4, hidden size (vector elements)
- DW, 8, signed element width
- N_LAYERS, 2, layers applied per token
- SEQ_LEN, 4, tokens per sequence (out_last period)
- TMO_W, 16, timeout counter width
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- abort  in  1  synchronous abort to IDLE
- timeout_limit  in  TMO_W  per-stage wait limit; 0 disables
- in_valid  in  1  token offered
- in_ready  out  1  token accepted when in_valid&in_ready
- in_vec  in  D×DW signed  token vector
- stage_start  out  1  one-cycle start pulse to engine
- stage_op  out  2  OP_LN1=0, OP_ATT=1, OP_LN2=2, OP_FFN=3
- layer_idx  out  $clog2(N_LAYERS)+1  current layer (selects engine weights)
- stage_in  out  D×DW signed  engine operand, stable for the whole stage
- stage_done  in  1  engine result valid
- stage_out  in  D×DW signed  engine result
- out_valid  out  1  result offered
- out_ready  in  1  result consumed when out_valid&out_ready
- out_vec  out  D×DW signed  result vector
- out_last  out  1  qualifies last token of sequence
- busy  out  1  state≠IDLE
- timeout_err  out  1  sticky stage-timeout flag

## Operation
- States: IDLE, LN1, ATT, LN2, FFN, OUT. Registers: res[D], tmp[D], layer, wait_cnt, tok_idx.
- IDLE: in_ready = !abort. On accept: res←in_vec, layer←0, go to LN1.
- Stage states drive stage_op and layer_idx. stage_start is high on the entry cycle only.
- stage_in source: res in LN1 and LN2; tmp in ATT and FFN.
- stage_done is honoured only when stage_start=0. It is ignored in IDLE and OUT.
- LN1 on done: tmp←stage_out, go to ATT.
- ATT on done: res←sat(res+stage_out), go to LN2.
- LN2 on done: tmp←stage_out, go to FFN.
- FFN on done: res←sat(res+stage_out). If layer=N_LAYERS-1, go to OUT; otherwise layer←layer+1 and go to LN1.
- sat(): DW+1-bit signed sum, clamped to [−2^(DW−1), 2^(DW−1)−1], per element.
- OUT: out_valid=1, out_vec=res, out_last=(tok_idx==SEQ_LEN−1). On handshake: tok_idx wraps mod SEQ_LEN, go to IDLE.
- Timeout: wait_cnt←0 on stage entry, then +1 per cycle.
  - If timeout_limit≠0, wait_cnt==timeout_limit and no done: timeout_err←1, drop the token (tok_idx unchanged), go to IDLE.
  - done in the same cycle as the limit: done wins.
- abort (any state, highest priority): next state IDLE; stage_start←0, out_valid←0, tok_idx←0, timeout_err←0.

## Timing
- Reset values: state IDLE, in_ready=1 after release, stage_start=0, stage_op=0, layer_idx=0, stage_in=0, out_valid=0, out_vec=0, out_last=0, busy=0, timeout_err=0, res/tmp/tok_idx/wait_cnt=0. Reset takes effect immediately, including mid-operation.
- An engine with latency L (done L≥1 cycles after start) gives L+1 cycles per stage.
- Accept at edge T: first out_valid in cycle T+1+4·N_LAYERS·(L+1).
- No token overlap: in_ready=0 from accept until the cycle after the output handshake.
- out_vec and out_last hold stable while out_valid & !out_ready.

## Structure
- Shared package transformer_pkg holds:
  - stage_op_t enum (OP_LN1..OP_FFN)
  - seq state_t enum
  - function sat_add(a,b,DW)
- Sub-module residual_sat_add #(D,DW): combinational vector saturating adder, used for both residual updates.

## Test plan
- Reset: pull rst_n low during FFN of layer 1 → same-cycle out_valid=0, busy=0, stage_start=0; after release in_ready=1.
- Pass-through engine (LN=identity, ATT=0, FFN=0, L=1), in_vec {1,2,3,4} → out_vec {1,2,3,4} at T+17; stage_op sequence 0,1,2,3,0,1,2,3 with layer_idx 0,0,0,0,1,1,1,1; exactly one stage_start per stage.
- Saturation: ATT returns 100 per element, FFN returns 0, in {100,−128,0,27} → after layer 0 {127,−28,100,127}; final out {127,72,127,127}.
- Backpressure and last flag: 5 tokens, out_ready low 5 cycles on token 2 → out_vec stable, in_ready=0 throughout; out_last=1 only on token 4; token 5 out_last=0.
- Timeout: limit=3, engine silent in ATT → timeout_err=1 and in_ready=1 four cycles after ATT entry, token dropped; repeat with done in the limit cycle → no error, advance to LN2.
- Abort asserted during LN2 with timeout_err set → next cycle busy=0, timeout_err=0, stage_start=0. abort with in_valid in IDLE → no accept.
